mw_wbuf: RTL and testbench

MW_WBUF -- requirements
Module: mw_wbuf

---
 rtl/mw_pkg.sv | 28 ++
 rtl/mw_wbuf_if.sv | 22 ++
 rtl/mw_sbuf.sv | 59 +++++
 rtl/mw_wbuf.sv | 159 +++++++++++++++
 tb/tb_mw_wbuf.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mw_pkg.sv
// -----------------------------------------------------------------------------
// mw_pkg -- shared definitions for the memory-writeback store buffer.
//   * opsize_t      : operand size encoding (11 is treated as dword)
//   * FLAG_*        : EFLAGS bit positions produced by mw_wbuf
//   * drain_state_t : state encoding of the store-drain FSM
// -----------------------------------------------------------------------------
package mw_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE      = 2'b00,
        SZ_WORD      = 2'b01,
        SZ_DWORD     = 2'b10,
        SZ_DWORD_ALT = 2'b11
    } opsize_t;

    localparam int FLAG_CF = 0;
    localparam int FLAG_PF = 2;
    localparam int FLAG_AF = 4;
    localparam int FLAG_ZF = 6;
    localparam int FLAG_SF = 7;
    localparam int FLAG_OF = 11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } drain_state_t;

endpackage

// File: rtl/mw_wbuf_if.sv
// -----------------------------------------------------------------------------
// mw_wbuf_if -- memory write request channel between mw_wbuf and memory.
//   mem_req  : write request pending (held until mem_ack)
//   mem_addr : request address
//   mem_data : request data
//   mem_size : request opsize
//   mem_ack  : memory accepted the current request
// Modports: master (store buffer side), slave (memory side).
// -----------------------------------------------------------------------------
interface mw_wbuf_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [1:0]        mem_size;
    logic              mem_ack;

    modport master (output mem_req, mem_addr, mem_data, mem_size, input mem_ack);
    modport slave  (input mem_req, mem_addr, mem_data, mem_size, output mem_ack);
endinterface

// File: rtl/mw_sbuf.sv
// -----------------------------------------------------------------------------
// mw_sbuf -- parametrised FIFO holding buffered stores.
//   clk, rst : clock, asynchronous active-high reset (clears pointers/count)
//   push     : write wdata at the tail
//   pop      : discard the head entry
//   wdata    : entry to push
//   head     : current head entry (stable until popped)
//   count    : number of occupied entries (0..DEPTH)
//   empty    : count == 0
// The caller never pushes when full or pops when empty.
// -----------------------------------------------------------------------------
module mw_sbuf #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] store_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: the storage array has no reset; count and pointers alone decide
    // which entries are valid, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (push) begin
            store_mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = store_mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/mw_wbuf.sv
// -----------------------------------------------------------------------------
// mw_wbuf -- memory-writeback stage with a store buffer.
//   Register writes go straight to the register file; stores to memory
//   operands are queued in mw_sbuf and drained one at a time over mem.
//   clk, rst      : clock, asynchronous active-high reset
//   v, we, rmsel  : stage valid, writes result, destination is r/m operand
//   modrm, opsize : ModR/M byte, operand size
//   aluval, addr  : result and effective address
//   af, cf, of    : ALU flags; flag_ld : per-bit flag-load mask
//   v_rf_ld, drid : register-file load and destination id
//   v_flag_ld     : flag-load mask gated by valid/stall
//   flags         : EFLAGS image derived from the result
//   mw_stall      : store arrives while buffer full
//   sb_count      : occupied entries; sb_empty : buffer empty
//   mem           : write request channel (mw_wbuf_if.master)
//   stall_cnt     : saturating stall-cycle counter, only when the
//                   MW_WBUF_PERF_EN macro is defined
// -----------------------------------------------------------------------------
module mw_wbuf
    import mw_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   v,
    input  logic                   we,
    input  logic                   rmsel,
    input  logic [7:0]             modrm,
    input  logic [1:0]             opsize,
    input  logic [DATA_W-1:0]      aluval,
    input  logic [ADDR_W-1:0]      addr,
    input  logic                   af,
    input  logic                   cf,
    input  logic                   of,
    input  logic [31:0]            flag_ld,
    output logic                   v_rf_ld,
    output logic [2:0]             drid,
    output logic [31:0]            v_flag_ld,
    output logic [31:0]            flags,
    output logic                   mw_stall,
    output logic [$clog2(DEPTH):0] sb_count,
    output logic                   sb_empty,
    mw_wbuf_if.master              mem
`ifdef MW_WBUF_PERF_EN
    ,
    output logic [15:0]            stall_cnt
`endif
);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W + 2;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic               store;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    drain_state_t       state;

    // A store is a write whose r/m destination is a memory operand (mod != 11).
    assign store    = v & we & rmsel & (modrm[7:6] != 2'b11);
    // Full is judged on the registered count: a pop this cycle does not help.
    assign mw_stall = store & (sb_count == FULL_CNT);
    assign push     = store & ~mw_stall;
    assign pop      = (state == ST_REQ) & mem.mem_ack;

    assign v_rf_ld   = v & we & ~store & ~mw_stall;
    assign drid      = rmsel ? modrm[2:0] : modrm[5:3];
    assign v_flag_ld = (v & ~mw_stall) ? flag_ld : 32'h0;

    mw_sbuf #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_sbuf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({addr, aluval, opsize}),
        .head  (head),
        .count (sb_count),
        .empty (sb_empty)
    );

    assign {mem.mem_addr, mem.mem_data, mem.mem_size} = head;

    // Drain FSM. Leaving IDLE on a same-cycle push puts mem_req up the cycle
    // right after the push edge. Leaving REQ considers a concurrent push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            mem.mem_req <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!sb_empty || push) begin
                        state       <= ST_REQ;
                        mem.mem_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (mem.mem_ack && !((sb_count > ONE_CNT) || push)) begin
                        state       <= ST_IDLE;
                        mem.mem_req <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    mem.mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Flags are evaluated on a zero-extended copy so narrow DATA_W builds
    // can still select word/dword slices.
    logic [31:0] val32;
    logic        zf;
    logic        sf;

    always_comb begin
        val32 = 32'(aluval);
        case (opsize_t'(opsize))
            SZ_BYTE: begin
                zf = (val32[7:0] == 8'h0);
                sf = val32[7];
            end
            SZ_WORD: begin
                zf = (val32[15:0] == 16'h0);
                sf = val32[15];
            end
            default: begin
                zf = (val32 == 32'h0);
                sf = val32[31];
            end
        endcase
        flags          = 32'h0;
        flags[FLAG_CF] = cf;
        flags[FLAG_PF] = ~^val32[7:0];
        flags[FLAG_AF] = af;
        flags[FLAG_ZF] = zf;
        flags[FLAG_SF] = sf;
        flags[FLAG_OF] = of;
    end

`ifdef MW_WBUF_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'h0;
        end else if (mw_stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mw_wbuf.sv
// -----------------------------------------------------------------------------
// tb_mw_wbuf -- directed bench for mw_wbuf (DEPTH=4, 32-bit data/address).
// Accepted stores push their expected write into a scoreboard queue; a
// monitor on the falling edge pops and compares on every mem_req & mem_ack.
// Combinational outputs are compared directly against hand-computed values.
// -----------------------------------------------------------------------------
module tb_mw_wbuf;
    import mw_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        v, we, rmsel;
    logic [7:0]  modrm;
    logic [1:0]  opsize;
    logic [31:0] aluval, addr;
    logic        af, cf, of;
    logic [31:0] flag_ld;
    logic        v_rf_ld;
    logic [2:0]  drid;
    logic [31:0] v_flag_ld, flags;
    logic        mw_stall;
    logic [2:0]  sb_count;
    logic        sb_empty;
`ifdef MW_WBUF_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    mw_wbuf_if #(.DATA_W(32), .ADDR_W(32)) mem_if ();

    mw_wbuf #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .v         (v),
        .we        (we),
        .rmsel     (rmsel),
        .modrm     (modrm),
        .opsize    (opsize),
        .aluval    (aluval),
        .addr      (addr),
        .af        (af),
        .cf        (cf),
        .of        (of),
        .flag_ld   (flag_ld),
        .v_rf_ld   (v_rf_ld),
        .drid      (drid),
        .v_flag_ld (v_flag_ld),
        .flags     (flags),
        .mw_stall  (mw_stall),
        .sb_count  (sb_count),
        .sb_empty  (sb_empty),
        .mem       (mem_if.master)
`ifdef MW_WBUF_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        v = 1'b1; we = 1'b1; rmsel = 1'b1; modrm = 8'h05;
        addr = a; aluval = d; opsize = sz;
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        exp_t e;
        e.addr = a; e.data = d; e.size = sz;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: one transfer per cycle with mem_req & mem_ack.
    always @(negedge clk) begin
        if (!rst && mem_if.mem_req && mem_if.mem_ack) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", 64'(mem_if.mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("wr_addr", 64'(mem_if.mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_if.mem_data), 64'(e.data));
                check("wr_size", 64'(mem_if.mem_size), 64'(e.size));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; v = 1'b0; we = 1'b0; rmsel = 1'b0; modrm = 8'h00;
        opsize = 2'b10; aluval = 32'h0; addr = 32'h0;
        af = 1'b0; cf = 1'b0; of = 1'b0; flag_ld = 32'hFFFF_FFFF;
        mem_if.mem_ack = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_mem_req", 64'(mem_if.mem_req), 64'd0);
        check("rst_count",   64'(sb_count), 64'd0);
        check("rst_empty",   64'(sb_empty), 64'd1);
        check("rst_stall",   64'(mw_stall), 64'd0);
`ifdef MW_WBUF_PERF_EN
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        rst = 1'b0;

        // Register write, dword zero result
        v = 1'b1; we = 1'b1; rmsel = 1'b0; modrm = 8'hC8; aluval = 32'h0; opsize = 2'b10;
        #1;
        check("rf_v_rf_ld",   64'(v_rf_ld), 64'd1);
        check("rf_drid",      64'(drid), 64'd1);
        check("rf_flags",     64'(flags), 64'h44);
        check("rf_v_flag_ld", 64'(v_flag_ld), 64'hFFFF_FFFF);
        rmsel = 1'b1;  // mod=11: register destination chosen by r/m field
        #1;
        check("rf_rm_drid",    64'(drid), 64'd0);
        check("rf_rm_v_rf_ld", 64'(v_rf_ld), 64'd1);
        tick();
        check("rf_no_mem_req", 64'(mem_if.mem_req), 64'd0);
        check("rf_empty",      64'(sb_empty), 64'd1);

        // Flag vectors per opsize
        v = 1'b0;
        opsize = 2'b00; aluval = 32'h0000_0180; cf = 1'b1; af = 1'b1; of = 1'b1;
        #1;
        check("flags_byte", 64'(flags), 64'h891);
        opsize = 2'b01; aluval = 32'h0001_0000; cf = 1'b0; af = 1'b0; of = 1'b0;
        #1;
        check("flags_word", 64'(flags), 64'h44);
        opsize = 2'b11; aluval = 32'h8000_0000;
        #1;
        check("flags_dword11", 64'(flags), 64'h84);
        check("v_flag_ld_invalid", 64'(v_flag_ld), 64'd0);

        // mem_ack while idle and empty is ignored
        mem_if.mem_ack = 1'b1;
        tick();
        mem_if.mem_ack = 1'b0;
        check("idle_ack_req",   64'(mem_if.mem_req), 64'd0);
        check("idle_ack_count", 64'(sb_count), 64'd0);

        // Single store, acked in its third request cycle
        set_store(32'h1000, 32'hDEAD_BEEF, 2'b10);
        #1;
        check("st_v_rf_ld", 64'(v_rf_ld), 64'd0);
        check("st_stall",   64'(mw_stall), 64'd0);
        expect_write(32'h1000, 32'hDEAD_BEEF, 2'b10);
        tick();
        v = 1'b0;
        check("st_req_c1", 64'(mem_if.mem_req), 64'd1);
        check("st_count",  64'(sb_count), 64'd1);
        check("st_addr",   64'(mem_if.mem_addr), 64'h1000);
        tick();
        check("st_req_c2", 64'(mem_if.mem_req), 64'd1);
        tick();
        check("st_req_c3", 64'(mem_if.mem_req), 64'd1);
        mem_if.mem_ack = 1'b1;
        tick();
        mem_if.mem_ack = 1'b0;
        check("st_req_done", 64'(mem_if.mem_req), 64'd0);
        check("st_empty",    64'(sb_empty), 64'd1);

        // Fill to DEPTH, fifth store stalls until one entry drains
        for (int i = 0; i < 4; i++) begin
            set_store(32'h2000 + 32'(4 * i), 32'hA0 + 32'(i), 2'(i));
            #1;
            check("full_fill_stall", 64'(mw_stall), 64'd0);
            expect_write(32'h2000 + 32'(4 * i), 32'hA0 + 32'(i), 2'(i));
            tick();
        end
        set_store(32'h2010, 32'hA4, 2'b10);
        #1;
        check("full_count",     64'(sb_count), 64'd4);
        check("full_stall",     64'(mw_stall), 64'd1);
        check("full_v_flag_ld", 64'(v_flag_ld), 64'd0);
        check("full_v_rf_ld",   64'(v_rf_ld), 64'd0);
        mem_if.mem_ack = 1'b1;
        tick();
        mem_if.mem_ack = 1'b0;
        #1;
        check("full_after_pop_count", 64'(sb_count), 64'd3);
        check("full_after_pop_stall", 64'(mw_stall), 64'd0);
        expect_write(32'h2010, 32'hA4, 2'b10);
        tick();
        v = 1'b0;
        check("full_refill_count", 64'(sb_count), 64'd4);
`ifdef MW_WBUF_PERF_EN
        check("perf_stall_cnt", 64'(stall_cnt), 64'd1);
`endif
        mem_if.mem_ack = 1'b1;
        repeat (4) tick();
        mem_if.mem_ack = 1'b0;
        check("full_drain_empty", 64'(sb_empty), 64'd1);
        check("full_drain_req",   64'(mem_if.mem_req), 64'd0);

        // Simultaneous push/pop at count 2, crossing the pointer wrap
        set_store(32'h3000, 32'hB0, 2'b00);
        expect_write(32'h3000, 32'hB0, 2'b00);
        tick();
        set_store(32'h3004, 32'hB1, 2'b01);
        expect_write(32'h3004, 32'hB1, 2'b01);
        tick();
        check("pp_count_start", 64'(sb_count), 64'd2);
        for (int k = 0; k < 4; k++) begin
            set_store(32'h3008 + 32'(4 * k), 32'hB2 + 32'(k), 2'b10);
            expect_write(32'h3008 + 32'(4 * k), 32'hB2 + 32'(k), 2'b10);
            mem_if.mem_ack = 1'b1;
            tick();
            check("pp_count_hold", 64'(sb_count), 64'd2);
        end
        v = 1'b0;
        repeat (2) tick();
        mem_if.mem_ack = 1'b0;
        check("pp_drain_empty", 64'(sb_empty), 64'd1);
        check("pp_drain_req",   64'(mem_if.mem_req), 64'd0);

        // Reset during a request with three buffered stores (discarded)
        for (int j = 0; j < 3; j++) begin
            set_store(32'h4000 + 32'(4 * j), 32'hC0 + 32'(j), 2'b10);
            tick();
        end
        v = 1'b0;
        #1;
        check("mr_count", 64'(sb_count), 64'd3);
        check("mr_req",   64'(mem_if.mem_req), 64'd1);
        mem_if.mem_ack = 1'b1;
        rst = 1'b1;
        #1;
        check("mr_rst_req",   64'(mem_if.mem_req), 64'd0);
        check("mr_rst_count", 64'(sb_count), 64'd0);
        check("mr_rst_empty", 64'(sb_empty), 64'd1);
`ifdef MW_WBUF_PERF_EN
        check("mr_rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        mem_if.mem_ack = 1'b0;
        check("mr_post_req",   64'(mem_if.mem_req), 64'd0);
        check("mr_post_count", 64'(sb_count), 64'd0);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
